// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with HI/LO registers and pipeline stall
// Optional madd/maddu support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_MDU,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDURD
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;

   logic [CNT_W-1:0] cnt;
   logic [63:0]      pend_res;
   logic             pend_wr;

   logic        is_mult;
   logic        is_div;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] b_safe;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [63:0] new_res;
   logic        new_wr;

   always_comb begin
      is_mult = 1'b0;
      is_div  = 1'b0;
      case (MDUOp)
         OP_MULT, OP_MULTU: is_mult = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU: is_mult = 1'b1;
`endif
         OP_DIV, OP_DIVU:   is_div  = 1'b1;
         default: ;
      endcase
   end

   // A zero divisor is replaced so the divider never produces X; the result is discarded anyway.
   always_comb begin
      prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
      prod_u = {32'd0, A} * {32'd0, B};
      b_safe = (B == 32'd0) ? 32'd1 : B;
      if (MDUOp == OP_DIV) begin
         quo = 32'($signed(A) / $signed(b_safe));
         rem = 32'($signed(A) % $signed(b_safe));
      end else begin
         quo = A / b_safe;
         rem = A % b_safe;
      end
   end

   always_comb begin
      new_res = 64'd0;
      new_wr  = 1'b1;
      case (MDUOp)
         OP_MULT:  new_res = prod_s;
         OP_MULTU: new_res = prod_u;
`ifdef MDU_MADD_EN
         OP_MADD:  new_res = {HI, LO} + prod_s;
         OP_MADDU: new_res = {HI, LO} + prod_u;
`endif
         OP_DIV, OP_DIVU: begin
            new_res = {rem, quo};
            new_wr  = (B != 32'd0);
         end
         default: new_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         HI       <= 32'd0;
         LO       <= 32'd0;
         cnt      <= '0;
         busy     <= 1'b0;
         pend_res <= 64'd0;
         pend_wr  <= 1'b0;
      end else if (busy) begin
         cnt <= cnt - 1'b1;
         if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            if (pend_wr) begin
               HI <= pend_res[63:32];
               LO <= pend_res[31:0];
            end
         end
      end else if (start) begin
         if (is_mult || is_div) begin
            busy     <= 1'b1;
            cnt      <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_res <= new_res;
            pend_wr  <= new_wr;
         end else if (MDUOp == OP_MTHI) begin
            HI <= A;
         end else if (MDUOp == OP_MTLO) begin
            LO <= A;
         end
      end
   end

   always_comb begin
      stall = D_MDU && (busy || (start && (is_mult || is_div)));
      case (MDUOp)
         OP_MFHI: MDURD = HI;
         OP_MFLO: MDURD = LO;
         default: MDURD = 32'd0;
      endcase
   end

endmodule
